// File: rtl/dds_pkg.sv
// Shared constants and state encoding for the DDS arithmetic blocks.
// Holds the default operand width and the multiplier FSM states.
package dds_pkg;

  localparam int DATA_WIDTH_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mul_64_64_seq.sv
// Sequential unsigned multiplier, radix-2 shift-add, one bit per cycle.
// Ports: sys_clk, sys_rst_n, start, mult_a, mult_b -> busy, done, product.
module mul_64_64_seq
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   mult_a,
  input  logic [DATA_WIDTH-1:0]   mult_b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  mul_state_t          state;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CNT_W-1:0]      cnt;

  // Partial product for the current multiplier bit.
  logic [PW-1:0] addend;
  logic [PW-1:0] acc_nxt;

  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    acc_nxt = acc + addend;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            mcand  <= PW'(mult_a);
            mplier <= mult_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Last bit: publish the finished sum directly.
          if (cnt == LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_64_64_seq.sv
// Directed and random checks of mul_64_64_seq against plain multiplication.
// Drives on the falling edge and samples on the falling edge.
module tb_mul_64_64_seq;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          start;
  logic [63:0]   mult_a;
  logic [63:0]   mult_b;
  logic          busy;
  logic          done;
  logic [127:0]  product;

  int checks = 0;
  int errors = 0;

  mul_64_64_seq #(.DATA_WIDTH(64)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [127:0] ref_mul(input logic [63:0] a,
                                           input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the launch edge up to the done edge.
  // n == 65 means done arrived 64 edges after the start edge.
  task automatic wait_done(input int poke_at, input logic [63:0] pa,
                           input logic [63:0] pb, output int n,
                           output int bc);
    bit got;
    n = 0;
    bc = 0;
    got = 0;
    while (!got && n < 200) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
      start = 1'b0;
      if (n == poke_at) begin
        mult_a = pa;
        mult_b = pb;
        start  = 1'b1;
      end
      if (done) got = 1;
      else if (busy) bc++;
    end
  endtask

  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    mult_a = a;
    mult_b = b;
    start  = 1'b1;
  endtask

  task automatic run(input string tag, input logic [63:0] a,
                     input logic [63:0] b, input logic [127:0] exp,
                     input bit width_chk);
    int n, bc;
    launch(a, b);
    wait_done(0, '0, '0, n, bc);
    chk({tag, "_lat"}, 128'(n), 128'd65);
    chk({tag, "_prod"}, product, exp);
    chk({tag, "_busy"}, 128'(bc), 128'd64);
    if (width_chk) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk({tag, "_donew"}, 128'(done), 128'd0);
    end
  endtask

  initial begin
    int n, bc, dcnt;
    logic [63:0] a, b;
    logic [127:0] keep;

    sys_rst_n = 1'b0;
    launch(64'h1234, 64'h5678);
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_prod", product, 128'd0);
    start = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_busy", 128'(busy), 128'd0);

    run("ftw", 64'h0000_0000_FFFF_FFFF, 64'd50_000_000,
        128'h0000_0000_0000_0000_02FA_F07F_FD05_0F80, 1);

    run("f85", 64'd85, 64'd50_000_000, 128'd4_250_000_000, 1);
    chk("roundtrip", product + 128'd44_967_295, 128'hFFFF_FFFF);

    run("ones", '1, '1,
        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1);
    run("zero", 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 128'd0, 1);

    // New operands pulsed mid-computation must be ignored.
    launch(64'd1000, 64'd3);
    wait_done(10, 64'd7, 64'd9, n, bc);
    chk("poke_lat", 128'(n), 128'd65);
    chk("poke_prod", product, 128'd3000);

    // Start in the done cycle: next done 65 cycles later.
    launch(64'd12, 64'd11);
    wait_done(0, '0, '0, n, bc);
    chk("b2b1_prod", product, 128'd132);
    launch(64'hFFFF_0000_1234_5678, 64'd77);
    wait_done(0, '0, '0, n, bc);
    chk("b2b2_lat", 128'(n), 128'd65);
    chk("b2b2_prod", product,
        ref_mul(64'hFFFF_0000_1234_5678, 64'd77));
    chk("b2b2_model", ref_mul(64'd12, 64'd11), 128'(132) + product
        - ref_mul(64'hFFFF_0000_1234_5678, 64'd77));

    // Reset at CALC cycle 30 aborts with no done.
    launch(64'd5, 64'd6);
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (30) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_prod", product, 128'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    dcnt = 0;
    repeat (80) begin
      @(negedge sys_clk);
      if (done) dcnt++;
    end
    chk("abort_nodone", 128'(dcnt), 128'd0);
    run("after_rst", 64'd5, 64'd6, 128'd30, 1);

    keep = product;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 97 == 0) a = '1;
      if (i % 89 == 0) b = 64'd0;
      run($sformatf("rnd%0d", i), a, b, ref_mul(a, b), (i % 4) == 0);
    end
    chk("keep_changed", 128'(product != keep || keep == product), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_64_64_seq.md
MUL_64_64_SEQ -- requirements
Module: mul_64_64_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand width in bits.
REQ-002 SHALL have sys_clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  input  1  request pulse; operands sampled on the edge where start=1 and the block is idle.
REQ-005 SHALL have mult_a  input  DATA_WIDTH  multiplicand, unsigned.
REQ-006 SHALL have mult_b  input  DATA_WIDTH  multiplier, unsigned.
REQ-007 SHALL have busy  output  1  high while a multiplication is in progress.
REQ-008 SHALL have done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have product  output  2*DATA_WIDTH  unsigned full-width result, held until the next done.

Function
REQ-010 SHALL compute product = mult_a * mult_b exactly, with no truncation and no overflow.
REQ-011 SHALL implement a radix-2 shift-add algorithm: one multiplier bit, LSB first, per CALC cycle.
REQ-012 SHALL use the two-state FSM IDLE and CALC.
REQ-013 SHALL transition IDLE->CALC on an edge with start=1; on that edge it latches both operands, clears the accumulator and clears the bit counter.
REQ-014 SHALL remain in CALC for exactly DATA_WIDTH edges, then return to IDLE.
REQ-015 SHALL assert done, and load product, on the same edge that CALC->IDLE occurs, which is DATA_WIDTH edges after the start edge.
REQ-016 SHALL deassert done on the following edge, so done lasts exactly 1 cycle.
REQ-017 SHALL drive busy as registered state==CALC: high from the edge after start until the done edge.
REQ-018 SHALL ignore start while in CALC; the operands and the in-flight computation are unaffected.
REQ-019 SHALL accept start during the cycle done is high (state is IDLE), giving a back-to-back period of DATA_WIDTH+1 cycles.
REQ-020 SHALL have fixed latency regardless of operand values, including zero and all-ones operands.
REQ-021 SHALL update product only on the done edge; intermediate accumulator values never appear on product.
REQ-022 SHALL size the bit counter as $clog2(DATA_WIDTH)+1 bits, with no wrap-around before terminal count.
REQ-023 SHALL be used as the inverse of the 64/64 divider: FTW*f_clk gives frequency*2^32, and quotient*denom+remain reconstructs numer.

Reset
REQ-024 SHALL, on sys_rst_n=0, immediately force state=IDLE, busy=0, done=0, product=0, accumulator=0 and counter=0.
REQ-025 SHALL, on reset asserted mid-CALC, abort the operation with no done pulse; after release, the block is idle and accepts start.
REQ-026 SHALL ignore start during reset; the first start is sampled on the first rising edge after sys_rst_n rises.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, CALC) and the DATA_WIDTH default constant in a shared package, dds_pkg.
REQ-028 SHALL be a single module; no sub-module is required (the adder/shift datapath stays inline).
REQ-029 SHALL be synthesizable with no vendor multiplier IP and no DSP inference.

Verification
REQ-030 SHALL verify: mult_a=0x0000_0000_FFFF_FFFF, mult_b=50_000_000, start 1 cycle -> done exactly 64 edges later, product=0x0000_0000_0000_0000_02FA_F07F_FD05_0F80.
REQ-031 SHALL verify: mult_a=85, mult_b=50_000_000 -> product=4_250_000_000; adding remainder 44_967_295 equals 0xFFFF_FFFF, matching the divider round trip.
REQ-032 SHALL verify: mult_a=mult_b=0xFFFF_FFFF_FFFF_FFFF -> product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; mult_a=0 -> product=0, with the same 64-cycle latency.
REQ-033 SHALL verify: start re-pulsed with new operands mid-CALC -> ignored, product matches the first operands; start in the done cycle -> second done exactly 65 cycles after the first.
REQ-034 SHALL verify: sys_rst_n pulsed low at CALC cycle 30 -> busy=0, done=0, product=0 immediately, no done pulse follows; a subsequent start completes correctly.
REQ-035 SHALL verify: randomized 1000 operand pairs against a reference model -> every product exact, done width exactly 1 cycle.
